fifo_write_arbiter: RTL and testbench



---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 32 +++
 rtl/fifo_write_arbiter.sv | 113 +++++++++++
 tb/tb_fifo_write_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Index increment with wrap at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first request at or after ptr_i, wrapping.
// Zero latency; no backpressure (pure function of its inputs).
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  logic [IW:0] cand;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_i} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (!any_o && req_i[cand[IW-1:0]]) begin
        any_o                 = 1'b1;
        idx_o                 = cand[IW-1:0];
        onehot_o[cand[IW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-locked sharer of the async FIFO write port; burst locking under FIFO_WARB_BURST_EN.
// Latency: one arbitration cycle before the first beat; backpressure: registered wfull stalls the owner.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4,
  parameter int IW        = $clog2(NREQ)
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ-1:0]  req_last,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  req_ready,
  input  logic             wfull,
  output logic             winc,
  output logic [DW-1:0]    wdata,
  output logic [IW-1:0]    gnt_id,
  output logic             busy
);

  arb_state_t      state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   gnt_id_q, gnt_id_d;
  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            own_vld;
  logic            beat;
  logic            burst_done;
  logic            unused_oh;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i    (req_valid),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  assign unused_oh = ^pick_oh;
  assign own_vld   = req_valid[gnt_id_q];
  assign beat      = (state_q == ARB_BUSY) && own_vld && !wfull;

`ifdef FIFO_WARB_BURST_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only moves on real beats, so a wfull stall freezes it.
  assign burst_done = req_last[gnt_id_q] || ((cnt_q + CW'(1)) == CW'(MAX_BURST));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ARB_IDLE && pick_any) cnt_d = '0;
    else if (beat)                      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge wclk) begin
    if (wrst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign burst_done  = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_id_d  = gnt_id_q;
    req_ready = '0;
    winc      = 1'b0;
    wdata     = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          gnt_id_d = pick_idx;
          state_d  = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        req_ready[gnt_id_q] = !wfull;
        winc                = beat;
        wdata               = req_data[gnt_id_q*DW +: DW];
        // An owner that goes quiet gives up its grant even during a stall.
        if ((beat && burst_done) || !own_vld) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = IW'(rr_next(int'(gnt_id_q), NREQ));
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      gnt_id_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_id_q <= gnt_id_d;
    end
  end

  assign busy   = (state_q == ARB_BUSY);
  assign gnt_id = gnt_id_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized and directed bench for fifo_write_arbiter against a behavioural arbitration model.
module tb_fifo_write_arbiter;
  localparam int NREQ = 4, DW = 8, MAX_BURST = 4, IW = $clog2(NREQ);
`ifdef FIFO_WARB_BURST_EN
  localparam int EFF_MAX = MAX_BURST;
  localparam bit USE_LAST = 1'b1;
`else
  localparam int EFF_MAX = 1;
  localparam bit USE_LAST = 1'b0;
`endif

  logic wclk = 1'b0;
  logic wrst;
  logic [NREQ-1:0] req_valid, req_last, req_ready;
  logic [NREQ*DW-1:0] req_data;
  logic wfull, winc, busy;
  logic [DW-1:0] wdata;
  logic [IW-1:0] gnt_id;

  always #5 wclk = ~wclk;

  fifo_write_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .wfull(wfull), .winc(winc),
    .wdata(wdata), .gnt_id(gnt_id), .busy(busy)
  );

  int n_cmp = 0, n_err = 0;
  // model: owner (-1 = no grant), last registered grant, pointer, beats in grant
  int m_owner = -1, m_gnt = 0, m_ptr = 0, m_cnt = 0;
  int seq[NREQ];
  int dut_grants[$];
  int dut_beats[$];
  int n_wr = 0;
  bit prev_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] beat_dat(input int i, input int s);
    return DW'(i * 64 + (s % 64));
  endfunction

  task automatic drive_data();
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = beat_dat(i, seq[i]);
  endtask

  task automatic check_outputs();
    logic [NREQ-1:0] er;
    bit ew;
    er = '0;
    ew = 1'b0;
    if (m_owner >= 0) begin
      er[m_owner] = !wfull;
      ew = req_valid[m_owner] && !wfull;
    end
    chk("busy", busy, m_owner >= 0);
    chk("gnt_id", gnt_id, m_gnt);
    chk("req_ready", req_ready, er);
    chk("winc", winc, ew);
    if (ew) chk("wdata", wdata, beat_dat(m_owner, seq[m_owner]));
    else if (m_owner < 0) chk("wdata_idle", wdata, 0);
  endtask

  task automatic model_step();
    int o;
    if (wrst) begin
      m_owner = -1; m_gnt = 0; m_ptr = 0; m_cnt = 0;
      return;
    end
    if (m_owner < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_ptr + k) % NREQ;
        if (req_valid[c]) begin
          m_owner = c; m_gnt = c; m_cnt = 0;
          break;
        end
      end
    end else begin
      o = m_owner;
      if (req_valid[o] && !wfull) begin
        m_cnt++;
        seq[o]++;
        if ((USE_LAST && req_last[o]) || m_cnt == EFF_MAX) begin
          m_ptr = (o + 1) % NREQ; m_owner = -1;
        end
      end else if (!req_valid[o]) begin
        m_ptr = (o + 1) % NREQ; m_owner = -1;
      end
    end
  endtask

  task automatic run_cycle();
    @(negedge wclk);
    check_outputs();
    if (busy === 1'b1 && !prev_busy) begin
      dut_grants.push_back(int'(gnt_id));
      dut_beats.push_back(0);
    end
    if (winc === 1'b1) begin
      n_wr++;
      if (dut_beats.size() > 0) dut_beats[dut_beats.size()-1]++;
    end
    prev_busy = (busy === 1'b1);
    model_step();
    @(posedge wclk);
    #1;
    drive_data();
  endtask

  task automatic do_reset(input int n);
    wrst = 1'b1; req_valid = '0; req_last = '0; wfull = 1'b0;
    for (int i = 0; i < n; i++) run_cycle();
    wrst = 1'b0;
    dut_grants.delete();
    dut_beats.delete();
  endtask

  initial begin
    int s0, s1, acc, nfull, wr0, ng, seen;
    for (int i = 0; i < NREQ; i++) seq[i] = 0;
    wrst = 1'b1; req_valid = '0; req_last = '0; wfull = 1'b0;
    drive_data();
    @(posedge wclk);
    #1;

    // idle after reset
    do_reset(2);
    for (int i = 0; i < 10; i++) run_cycle();

    // all requesting, no last: rotation and burst length
    do_reset(1);
    req_valid = '1;
    for (int i = 0; i < 5 * (EFF_MAX + 1) + 1; i++) run_cycle();
    chk("rot_ngrants_ok", dut_grants.size() >= 5, 1);
    if (dut_grants.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk($sformatf("rot_grant%0d", i), dut_grants[i], i % NREQ);
      for (int i = 0; i < 4; i++) chk($sformatf("rot_beats%0d", i), dut_beats[i], EFF_MAX);
    end

    // requester 2 alone, last on beat 2, then pointer must sit at 3
    do_reset(1);
    s0 = seq[2]; wr0 = n_wr;
    for (int i = 0; i < 12; i++) begin
      acc = seq[2] - s0;
      req_valid = '0; req_last = '0;
      req_valid[2] = (acc < 2);
      req_last[2] = (acc == 1);
      run_cycle();
    end
    chk("last_writes", n_wr - wr0, 2);
    ng = dut_grants.size();
    req_valid = '0; req_last = '0;
    req_valid[0] = 1'b1; req_valid[3] = 1'b1;
    for (int i = 0; i < 3; i++) run_cycle();
    chk("after_last_grant_seen", dut_grants.size() > ng, 1);
    if (dut_grants.size() > ng) chk("after_last_grant", dut_grants[ng], 3);

    // wfull stall for 5 cycles mid-burst
    do_reset(1);
    s1 = seq[1]; wr0 = n_wr; nfull = 0;
    for (int i = 0; i < 30; i++) begin
      acc = seq[1] - s1;
      req_valid = '0; req_last = '0;
      req_valid[1] = (acc < 4);
      wfull = (acc == 2 && nfull < 5);
      if (wfull) nfull++;
      run_cycle();
    end
    wfull = 1'b0;
    chk("stall_full_cycles", nfull, 5);
    chk("stall_writes", n_wr - wr0, 4);
    chk("stall_grants", dut_grants.size(), (EFF_MAX == 1) ? 4 : 1);

    // owner 0 drops valid after 2 beats, requester 1 waiting
    do_reset(1);
    s0 = seq[0]; s1 = seq[1];
    for (int i = 0; i < 20; i++) begin
      acc = seq[0] - s0;
      req_valid = '0; req_last = '0;
      req_valid[0] = (acc < 2);
      req_valid[1] = 1'b1;
      run_cycle();
    end
    chk("drop_writes0", seq[0] - s0, 2);
    chk("drop_ngrants_ok", dut_grants.size() >= 2, 1);
    if (dut_grants.size() >= 2) begin
      chk("drop_grant0", dut_grants[0], 0);
      chk("drop_grant1", dut_grants[1], 1);
    end

    // reset during the second write of a burst
    do_reset(1);
    req_valid = '1; req_last = '0;
    wr0 = n_wr; seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      if (n_wr - wr0 == 1 && busy === 1'b1) seen = 1;
      else run_cycle();
    end
    chk("rst_mid_reached", seen, 1);
    wrst = 1'b1;
    run_cycle();
    wrst = 1'b0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_gnt", gnt_id, 0);
    chk("rst_mid_winc", winc, 0);
    for (int i = 0; i < 8; i++) run_cycle();

    // random traffic with occasional stalls and resets
    for (int i = 0; i < 800; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        req_valid[r] = ($urandom_range(0, 9) < 7);
        req_last[r] = ($urandom_range(0, 3) == 0);
      end
      wfull = ($urandom_range(0, 4) == 0);
      wrst = ($urandom_range(0, 99) == 0);
      run_cycle();
    end
    wrst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
